inert_multi_axis_seq: RTL and testbench
=======================================

Name: inert_multi_axis_seq

Overview:
- Parametrised successor to the single-axis Z-gyro sequencer. It drives an external SPI master over a snd/cmd/done/resp handshake.
- Sequence: power-up delay, then a 3-write sensor configuration. After that, each time the synchronised INT is seen it burst-reads NUM_AXES consecutive 16-bit axis registers (low byte, then high byte).
- Publishes all axes atomically with a 1-cycle vld pulse. Sits between SPI_mnrch and the integrator/fusion logic.
- Adds an overrun flag and a runtime axis-count limit, neither of which the single-axis version has.

Parameters:
- NUM_AXES, 3, max axes read per sample (1..6); output bus width is 16*NUM_AXES.
- BASE_ADDR, 7'h22, sensor address of axis 0 low byte; axis i low = BASE_ADDR+2i, high = BASE_ADDR+2i+1.
- PWR_DLY, 65535, cycles in PWR_WAIT before the first config write.
- FAST_SIM, 1, when 1, PWR_DLY is replaced by 511.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- INT  in  1  sensor data-ready, asynchronous; double-flopped internally.
- act_axes  in  3  number of axes to read this sample; 0 or >NUM_AXES is treated as NUM_AXES. Sampled on leaving WAIT_INT.
- clr_ovr  in  1  clears ovr (and ovr_cnt when the optional feature is built).
- done  in  1  SPI master transaction complete, 1-cycle pulse.
- resp  in  16  SPI response; valid while done=1; byte used is resp[7:0].
- snd  out  1  1-cycle request to the SPI master.
- cmd  out  16  command; must be valid in every cycle snd=1.
- rates  out  16*NUM_AXES  axis i in bits [16i+15:16i], {high,low}.
- vld  out  1  1-cycle pulse when rates is updated.
- ovr  out  1  sticky: a sample was missed.
- busy  out  1  high in any state other than WAIT_INT.
- ovr_cnt  out  8  dropped-sample count; all zeros if the feature is absent.

Behaviour:
- Reset values (rst=1 at a clk edge): state=PWR_WAIT, delay timer=0, INT sync flops=0, snd=0, cmd=0, rates=0, vld=0, ovr=0, ovr_cnt=0, busy=1. All shadow byte registers are cleared.
- Reset mid-transaction: the sequencer aborts, and any done pulse arriving in PWR_WAIT is ignored.
- PWR_WAIT: timer counts up from 0. When it reaches the effective PWR_DLY, assert snd with cmd=16'h0D02 and go to CFG with index 0.
- CFG: on each done, increment the index and send the next write: 16'h1160, then 16'h1440. On the done of the third write, go to WAIT_INT with snd=0. Writes are never re-issued.
- WAIT_INT: cmd is a don't-care. When the synchronised INT is 1, latch n=act_axes (clamped), send the read of axis 0 low, set k=0, and go to RD.
- Read command format: {1'b1, addr[6:0], 8'h00}.
- RD: on each done, capture resp[7:0] into shadow byte k (even k = low byte, odd k = high byte of axis k/2), then increment k.
  - If k+1 < 2n: assert snd in the same cycle with the read for byte k+1 (zero-bubble chaining).
  - Otherwise: go to PUB with no snd.
- PUB (1 cycle): copy the shadow bytes of axes 0..n-1 into rates, assert vld, go to WAIT_INT.
  - Axes n..NUM_AXES-1 in rates keep their previous values.
  - End-to-end latency: last done to vld is exactly 1 cycle.
- Overrun: a rising edge of the synchronised INT while busy=1 and state is RD or PUB sets ovr. ovr persists until clr_ovr.
  - clr_ovr and a new overrun in the same cycle: set wins.
- INT edges in PWR_WAIT/CFG are ignored and are not overruns.
- INT still high on return to WAIT_INT starts a new burst immediately (level-sensitive).
- done outside CFG/RD, or in the same cycle as snd from WAIT_INT, is ignored.
- snd is never asserted in two consecutive cycles.

Optional Feature:
- Macro INERT_OVR_CNT_EN.
- Defined: ovr_cnt increments (saturating at 8'hFF) on each overrun event and clears to 0 on clr_ovr. Set beats clear, leaving ovr_cnt=1.
- Undefined: ovr_cnt is tied to 8'h00 and there is no counter logic; ovr behaves as above.

Test Plan:
- Power-up, FAST_SIM=1, rst released: snd first seen with cmd=16'h0D02 at cycle 511 after release. Then 16'h1160 and 16'h1440, each in the same cycle as the previous done. Then busy=0.
- NUM_AXES=3, act_axes=0, INT=1, model resp bytes 11,22,33,44,55,66: cmd sequence A200,A300,A400,A500,A600,A700. One cycle after the 6th done: vld=1 and rates={16'h6655,16'h4433,16'h2211}.
- act_axes=1 with previous rates={6655,4433,2211}, resp bytes 0xAA,0xBB: only A200 and A300 are issued. rates becomes {6655,4433,BBAA}.
- INT pulse rising edge while in RD: ovr=1. With INERT_OVR_CNT_EN, two overruns give ovr_cnt=2; clr_ovr returns ovr=0 and ovr_cnt=0.
- rst asserted between the 3rd and 4th done of a burst: the next cycle shows snd=0, rates=0, state PWR_WAIT. A stray done afterwards produces no snd and no vld.
- INT held high continuously: back-to-back bursts occur, with exactly 1 PUB cycle plus 1 WAIT_INT cycle between the last done and the next A200 snd. No ovr is set.

Source files
------------

// File: rtl/inert_multi_axis_seq.sv
// inert_multi_axis_seq: multi-axis inertial sensor sequencer driving an
// external SPI master. Power-up delay, 3-write configuration, then an
// INT-triggered burst read of up to NUM_AXES 16-bit axes, published
// atomically with a 1-cycle vld pulse.
// Optional build macro: INERT_OVR_CNT_EN enables the saturating ovr_cnt counter.
module inert_multi_axis_seq #(
  parameter int unsigned NUM_AXES  = 3,
  parameter logic [6:0]  BASE_ADDR = 7'h22,
  parameter int unsigned PWR_DLY   = 65535,
  parameter bit          FAST_SIM  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    INT,
  input  logic [2:0]              act_axes,
  input  logic                    clr_ovr,
  input  logic                    done,
  input  logic [15:0]             resp,
  output logic                    snd,
  output logic [15:0]             cmd,
  output logic [16*NUM_AXES-1:0]  rates,
  output logic                    vld,
  output logic                    ovr,
  output logic                    busy,
  output logic [7:0]              ovr_cnt
);

  localparam logic [15:0] DLY_EFF = FAST_SIM ? 16'd511 : 16'(PWR_DLY);
  localparam int unsigned NB      = 2 * NUM_AXES;
  localparam logic [2:0]  NAX     = 3'(NUM_AXES);

  typedef enum logic [2:0] {
    PWR_WAIT,
    CFG,
    WAIT_INT,
    RD,
    PUB
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] tmr;
  logic [1:0]  cfg_idx, cfg_idx_nxt;
  logic [3:0]  k, k_nxt, k_inc, nbytes;
  logic [2:0]  n_lat, n_nxt, act_clamp;
  logic        int_s1, int_s2, int_d;
  logic        ovr_evt;
  logic        pub_load;
  logic [7:0]  shadow [NB];
  logic [7:0]  byte_m [NB];
  logic        resp_hi_unused;

  // Only the low response byte carries register data.
  assign resp_hi_unused = ^resp[15:8];

  function automatic logic [15:0] rd_cmd(input logic [3:0] j);
    rd_cmd = {1'b1, BASE_ADDR + {3'b000, j}, 8'h00};
  endfunction

  assign act_clamp = (act_axes == 3'd0 || act_axes > NAX) ? NAX : act_axes;
  assign nbytes    = {n_lat, 1'b0};
  assign k_inc     = k + 4'd1;
  assign busy      = (state != WAIT_INT);
  assign ovr_evt   = int_s2 & ~int_d & ((state == RD) || (state == PUB));

  // Next-state, request and command generation.
  always_comb begin
    state_nxt   = state;
    cfg_idx_nxt = cfg_idx;
    k_nxt       = k;
    n_nxt       = n_lat;
    snd         = 1'b0;
    cmd         = '0;
    pub_load    = 1'b0;
    case (state)
      PWR_WAIT: begin
        if (tmr == DLY_EFF) begin
          snd         = 1'b1;
          cmd         = 16'h0D02;
          cfg_idx_nxt = 2'd0;
          state_nxt   = CFG;
        end
      end
      CFG: begin
        if (done) begin
          if (cfg_idx == 2'd2) begin
            state_nxt = WAIT_INT;
          end else begin
            cfg_idx_nxt = cfg_idx + 2'd1;
            snd         = 1'b1;
            cmd         = (cfg_idx == 2'd0) ? 16'h1160 : 16'h1440;
          end
        end
      end
      WAIT_INT: begin
        if (int_s2) begin
          n_nxt     = act_clamp;
          k_nxt     = 4'd0;
          snd       = 1'b1;
          cmd       = rd_cmd(4'd0);
          state_nxt = RD;
        end
      end
      RD: begin
        if (done) begin
          k_nxt = k_inc;
          if (k_inc < nbytes) begin
            snd = 1'b1;
            cmd = rd_cmd(k_inc);
          end else begin
            pub_load  = 1'b1;
            state_nxt = PUB;
          end
        end
      end
      PUB: state_nxt = WAIT_INT;
      default: state_nxt = PWR_WAIT;
    endcase
  end

  // State register, power-up timer and sequencing counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PWR_WAIT;
      tmr     <= '0;
      cfg_idx <= '0;
      k       <= '0;
      n_lat   <= NAX;
    end else begin
      state   <= state_nxt;
      cfg_idx <= cfg_idx_nxt;
      k       <= k_nxt;
      n_lat   <= n_nxt;
      if (state == PWR_WAIT && state_nxt == PWR_WAIT)
        tmr <= tmr + 16'd1;
    end
  end

  // INT double-flop synchroniser plus edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_s1 <= 1'b0;
      int_s2 <= 1'b0;
      int_d  <= 1'b0;
    end else begin
      int_s1 <= INT;
      int_s2 <= int_s1;
      int_d  <= int_s2;
    end
  end

  // Shadow bytes with the in-flight response merged in for the final byte.
  always_comb begin
    for (int unsigned i = 0; i < NB; i++)
      byte_m[i] = (k == 4'(i)) ? resp[7:0] : shadow[i];
  end

  // Capture read bytes; publish on the last done so rates and vld appear
  // together in the PUB cycle (one cycle after the last done).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NB; i++)
        shadow[i] <= '0;
      rates <= '0;
      vld   <= 1'b0;
    end else begin
      vld <= pub_load;
      if (state == RD && done) begin
        for (int unsigned i = 0; i < NB; i++)
          if (k == 4'(i)) shadow[i] <= resp[7:0];
      end
      if (pub_load) begin
        for (int unsigned i = 0; i < NUM_AXES; i++)
          if (3'(i) < n_lat)
            rates[16*i +: 16] <= {byte_m[2*i+1], byte_m[2*i]};
      end
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)            ovr <= 1'b0;
    else if (ovr_evt)   ovr <= 1'b1;
    else if (clr_ovr)   ovr <= 1'b0;
  end

`ifdef INERT_OVR_CNT_EN
  // Saturating dropped-sample counter; set beats clear (restarts at 1).
  always_ff @(posedge clk) begin
    if (rst)
      ovr_cnt <= '0;
    else if (ovr_evt)
      ovr_cnt <= clr_ovr ? 8'd1 : ((ovr_cnt == 8'hFF) ? ovr_cnt : ovr_cnt + 8'd1);
    else if (clr_ovr)
      ovr_cnt <= '0;
  end
`else
  assign ovr_cnt = '0;
`endif

endmodule

// File: tb/tb_inert_multi_axis_seq.sv
// Directed self-checking bench for inert_multi_axis_seq (NUM_AXES=3, FAST_SIM=1).
// A behavioural SPI master answers each snd with a done two cycles later.
module tb_inert_multi_axis_seq;

  logic        clk, rst, INT, clr_ovr, done;
  logic [2:0]  act_axes;
  logic [15:0] resp;
  logic        snd, vld, ovr, busy;
  logic [15:0] cmd;
  logic [47:0] rates;
  logic [7:0]  ovr_cnt;

`ifdef INERT_OVR_CNT_EN
  localparam logic [7:0] EXP_CNT1 = 8'd1;
  localparam logic [7:0] EXP_CNT2 = 8'd2;
`else
  localparam logic [7:0] EXP_CNT1 = 8'd0;
  localparam logic [7:0] EXP_CNT2 = 8'd0;
`endif

  inert_multi_axis_seq #(
    .NUM_AXES (3),
    .BASE_ADDR(7'h22),
    .PWR_DLY  (65535),
    .FAST_SIM (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .INT     (INT),
    .act_axes(act_axes),
    .clr_ovr (clr_ovr),
    .done    (done),
    .resp    (resp),
    .snd     (snd),
    .cmd     (cmd),
    .rates   (rates),
    .vld     (vld),
    .ovr     (ovr),
    .busy    (busy),
    .ovr_cnt (ovr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk, n_fail;
  int          cyc, pend, done_cnt, vld_cnt, last_done_cyc, last_vld_cyc;
  bit          mst_en, stray, prev_snd;
  logic [15:0] cmd_log[$];
  int          snd_cyc_log[$];
  logic [7:0]  byte_q[$];

  // One clock: drive master response after the edge, then sample outputs.
  task automatic step();
    logic [7:0] b;
    @(posedge clk);
    #1;
    cyc++;
    done = 1'b0;
    resp = 16'h0000;
    if (!mst_en) pend = 0;
    else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        b = 8'h00;
        if (byte_q.size() > 0) b = byte_q.pop_front();
        done = 1'b1;
        resp = {8'h5A, b};
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
    if (stray) begin
      done  = 1'b1;
      resp  = 16'h00C3;
      stray = 1'b0;
    end
    #1;
    if (snd) begin
      n_chk++;
      if (prev_snd) begin
        n_fail++;
        $display("FAIL snd_consecutive: snd=1 at cycle %0d after snd=1, required 0", cyc);
      end
      cmd_log.push_back(cmd);
      snd_cyc_log.push_back(cyc);
      if (mst_en) pend = 2;
    end
    prev_snd = snd;
    if (vld) begin
      vld_cnt++;
      last_vld_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; INT = 1'b0; clr_ovr = 1'b0; act_axes = 3'd0; mst_en = 1'b0;
    repeat (3) step();
    n_chk++; if (snd !== 1'b0)    begin n_fail++; $display("FAIL reset_snd: got %b want 0", snd); end
    n_chk++; if (cmd !== 16'h0)   begin n_fail++; $display("FAIL reset_cmd: got %h want 0000", cmd); end
    n_chk++; if (rates !== 48'h0) begin n_fail++; $display("FAIL reset_rates: got %h want 0", rates); end
    n_chk++; if (vld !== 1'b0)    begin n_fail++; $display("FAIL reset_vld: got %b want 0", vld); end
    n_chk++; if (ovr !== 1'b0)    begin n_fail++; $display("FAIL reset_ovr: got %b want 0", ovr); end
    n_chk++; if (busy !== 1'b1)   begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_chk++; if (ovr_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_ovr_cnt: got %h want 00", ovr_cnt); end
  endtask

  task automatic test_powerup();
    int k, d0;
    bit seen;
    mst_en = 1'b0; rst = 1'b1; INT = 1'b0;
    step();
    rst = 1'b0; mst_en = 1'b1;
    k = 0; seen = 1'b0;
    while (!seen && k < 600) begin
      step(); k++;
      if (snd) seen = 1'b1;
    end
    n_chk++; if (!seen || k != 511) begin n_fail++; $display("FAIL pwr_delay: first snd after %0d cycles (seen=%b), want 511", k, seen); end
    n_chk++; if (cmd !== 16'h0D02) begin n_fail++; $display("FAIL cfg_cmd0: got %h want 0D02", cmd); end
    for (int w = 0; w < 3; w++) begin
      d0 = done_cnt; k = 0;
      while (done_cnt == d0 && k < 10) begin step(); k++; end
      n_chk++; if (done_cnt == d0) begin n_fail++; $display("FAIL cfg_done_timeout: write %0d got no done, want done", w); end
      if (w < 2) begin
        n_chk++;
        if (snd !== 1'b1 || cmd !== ((w == 0) ? 16'h1160 : 16'h1440)) begin
          n_fail++; $display("FAIL cfg_cmd%0d: snd=%b cmd=%h want snd=1 cmd=%h", w + 1, snd, cmd, (w == 0) ? 16'h1160 : 16'h1440);
        end
      end else begin
        n_chk++; if (snd !== 1'b0) begin n_fail++; $display("FAIL cfg_end_snd: got %b want 0", snd); end
      end
    end
    step();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cfg_busy: got %b want 0", busy); end
  endtask

  task automatic test_burst3();
    int k, vc;
    logic [15:0] exp;
    act_axes = 3'd0; cmd_log.delete();
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    vc = vld_cnt; INT = 1'b1; k = 0;
    while (vld_cnt == vc && k < 80) begin
      step(); k++;
      if (cmd_log.size() > 0) INT = 1'b0;
    end
    n_chk++; if (vld_cnt == vc) begin n_fail++; $display("FAIL burst3_timeout: no vld, want vld"); end
    n_chk++; if (last_vld_cyc - last_done_cyc != 1) begin n_fail++; $display("FAIL burst3_latency: %0d cycles want 1", last_vld_cyc - last_done_cyc); end
    n_chk++; if (rates !== 48'h6655_4433_2211) begin n_fail++; $display("FAIL burst3_rates: got %h want 665544332211", rates); end
    n_chk++; if (cmd_log.size() != 6) begin n_fail++; $display("FAIL burst3_ncmd: got %0d want 6", cmd_log.size()); end
    for (int j = 0; j < 6; j++) begin
      exp = {8'hA2 + 8'(j), 8'h00};
      if (j < cmd_log.size()) begin
        n_chk++; if (cmd_log[j] !== exp) begin n_fail++; $display("FAIL burst3_cmd%0d: got %h want %h", j, cmd_log[j], exp); end
      end
    end
    step();
    n_chk++; if (vld !== 1'b0) begin n_fail++; $display("FAIL burst3_vld_pulse: got %b want 0", vld); end
    repeat (4) step();
  endtask

  task automatic test_partial();
    int k, vc;
    act_axes = 3'd1; cmd_log.delete();
    byte_q = '{8'hAA, 8'hBB};
    vc = vld_cnt; INT = 1'b1; k = 0;
    while (vld_cnt == vc && k < 60) begin
      step(); k++;
      if (cmd_log.size() > 0) INT = 1'b0;
    end
    n_chk++; if (vld_cnt == vc) begin n_fail++; $display("FAIL partial_timeout: no vld, want vld"); end
    n_chk++; if (rates !== 48'h6655_4433_BBAA) begin n_fail++; $display("FAIL partial_rates: got %h want 66554433BBAA", rates); end
    repeat (8) step();
    n_chk++; if (cmd_log.size() != 2) begin n_fail++; $display("FAIL partial_ncmd: got %0d want 2", cmd_log.size()); end
    if (cmd_log.size() == 2) begin
      n_chk++; if (cmd_log[0] !== 16'hA200 || cmd_log[1] !== 16'hA300) begin
        n_fail++; $display("FAIL partial_cmds: got %h %h want A200 A300", cmd_log[0], cmd_log[1]);
      end
    end
    act_axes = 3'd0;
  endtask

  task automatic test_overrun();
    n_chk++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_pre: got %b want 0", ovr); end
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    for (int i = 0; i < 25; i++) begin
      INT = (i == 0 || i == 1 || i == 4 || i == 5 || i == 8 || i == 9);
      step();
    end
    n_chk++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", ovr); end
    n_chk++; if (ovr_cnt !== EXP_CNT2) begin n_fail++; $display("FAIL ovr_cnt2: got %h want %h", ovr_cnt, EXP_CNT2); end
    clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
    n_chk++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %b want 0", ovr); end
    n_chk++; if (ovr_cnt !== 8'h00) begin n_fail++; $display("FAIL ovr_cnt_clr: got %h want 00", ovr_cnt); end
    step();
  endtask

  task automatic test_set_wins();
    byte_q = '{8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    for (int i = 0; i < 25; i++) begin
      INT     = (i == 0 || i == 1 || i == 4 || i == 5);
      clr_ovr = (i == 6);
      step();
      if (i == 6) begin
        n_chk++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL setwin_ovr: got %b want 1", ovr); end
        n_chk++; if (ovr_cnt !== EXP_CNT1) begin n_fail++; $display("FAIL setwin_cnt: got %h want %h", ovr_cnt, EXP_CNT1); end
      end
    end
    clr_ovr = 1'b0;
    n_chk++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL setwin_sticky: got %b want 1", ovr); end
    clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k, d0, sc, vc;
    cmd_log.delete();
    byte_q = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76};
    d0 = done_cnt; INT = 1'b1; k = 0;
    while (done_cnt < d0 + 3 && k < 60) begin
      step(); k++;
      if (cmd_log.size() > 0) INT = 1'b0;
    end
    n_chk++; if (done_cnt < d0 + 3) begin n_fail++; $display("FAIL rstmid_timeout: %0d dones want 3", done_cnt - d0); end
    n_chk++; if (rates === 48'h0) begin n_fail++; $display("FAIL rstmid_pre_rates: got %h want nonzero", rates); end
    rst = 1'b1; mst_en = 1'b0;
    step();
    n_chk++; if (snd !== 1'b0)    begin n_fail++; $display("FAIL rstmid_snd: got %b want 0", snd); end
    n_chk++; if (rates !== 48'h0) begin n_fail++; $display("FAIL rstmid_rates: got %h want 0", rates); end
    n_chk++; if (busy !== 1'b1)   begin n_fail++; $display("FAIL rstmid_busy: got %b want 1", busy); end
    rst = 1'b0; stray = 1'b1;
    sc = cmd_log.size(); vc = vld_cnt;
    repeat (6) step();
    n_chk++; if (cmd_log.size() != sc) begin n_fail++; $display("FAIL rstmid_stray_snd: %0d snds want 0", cmd_log.size() - sc); end
    n_chk++; if (vld_cnt != vc) begin n_fail++; $display("FAIL rstmid_stray_vld: %0d vlds want 0", vld_cnt - vc); end
  endtask

  task automatic test_back_to_back();
    int k, vc, ld, sz;
    act_axes = 3'd0; cmd_log.delete(); snd_cyc_log.delete(); byte_q.delete();
    vc = vld_cnt; ld = 0; sz = 0; INT = 1'b1; k = 0;
    while (vld_cnt < vc + 2 && k < 100) begin
      step(); k++;
      if (vld_cnt == vc + 1 && ld == 0) begin
        ld = last_done_cyc;
        sz = cmd_log.size();
      end
    end
    INT = 1'b0;
    n_chk++; if (vld_cnt < vc + 2) begin n_fail++; $display("FAIL b2b_timeout: %0d vlds want 2", vld_cnt - vc); end
    if (snd_cyc_log.size() > sz && ld != 0) begin
      n_chk++; if (snd_cyc_log[sz] - ld != 2) begin n_fail++; $display("FAIL b2b_gap: %0d cycles want 2", snd_cyc_log[sz] - ld); end
      n_chk++; if (cmd_log[sz] !== 16'hA200) begin n_fail++; $display("FAIL b2b_cmd: got %h want A200", cmd_log[sz]); end
    end else begin
      n_chk++; n_fail++; $display("FAIL b2b_second_burst: no second snd, want A200");
    end
    n_chk++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr: got %b want 0", ovr); end
    repeat (20) step();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; pend = 0; done_cnt = 0; vld_cnt = 0;
    last_done_cyc = 0; last_vld_cyc = 0; stray = 1'b0; prev_snd = 1'b0;
    done = 1'b0; resp = 16'h0;
    test_reset();
    test_powerup();
    test_burst3();
    test_partial();
    test_overrun();
    test_set_wins();
    test_reset_mid();
    test_powerup();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
